// File: rtl/adc_conv_sequencer.sv
// Frame controller for AD4003 ADC modules: CNV pulse, SCK burst window, data_valid strobe
// and a running sample counter, all on adc_spi_clk.
//   state   | meaning
//   S_IDLE  | waiting for acq_en with a legal period
//   S_CNV   | adc_cnv high, conversion start
//   S_WAIT  | conversion time, strobes low
//   S_SHIFT | SCK burst / capture shift window
//   S_LATCH | read-clock delay and shift-register settle
//   S_HOLD  | data_valid on entry, then pad to the frame period
module adc_conv_sequencer #(
  parameter int ADC_DATA_WIDTH   = 18,
  parameter int CNV_HIGH_CYCLES  = 4,
  parameter int CONV_WAIT_CYCLES = 24,
  parameter int READ_LAT         = 4,
  parameter int PERIOD_WIDTH     = 16
) (
  input  logic                    adc_spi_clk,
  input  logic                    rst,
  input  logic                    acq_en,
  input  logic [PERIOD_WIDTH-1:0] period_cfg,
  output logic                    adc_cnv,
  output logic                    adc_sck_en,
  output logic                    reader_en_sync,
  output logic                    data_valid,
  output logic [31:0]             sample_cnt,
  output logic                    busy,
  output logic                    cfg_err
);

  localparam int MIN_PERIOD = CNV_HIGH_CYCLES + CONV_WAIT_CYCLES + ADC_DATA_WIDTH + READ_LAT + 1;

  // Last frame-time index of each phase; t counts from 0 at the first CNV cycle.
  localparam logic [PERIOD_WIDTH-1:0] T_CNV_LAST   = PERIOD_WIDTH'(CNV_HIGH_CYCLES - 1);
  localparam logic [PERIOD_WIDTH-1:0] T_WAIT_LAST  = PERIOD_WIDTH'(CNV_HIGH_CYCLES + CONV_WAIT_CYCLES - 1);
  localparam logic [PERIOD_WIDTH-1:0] T_SHIFT_LAST = PERIOD_WIDTH'(CNV_HIGH_CYCLES + CONV_WAIT_CYCLES
                                                                 + ADC_DATA_WIDTH - 1);
  localparam logic [PERIOD_WIDTH-1:0] T_LATCH_LAST = PERIOD_WIDTH'(MIN_PERIOD - 2);
  localparam logic [PERIOD_WIDTH-1:0] P_MIN        = PERIOD_WIDTH'(MIN_PERIOD);

  typedef enum logic [2:0] {S_IDLE, S_CNV, S_WAIT, S_SHIFT, S_LATCH, S_HOLD} state_t;

  state_t                  r_state, w_state_nxt;
  logic [PERIOD_WIDTH-1:0] r_t, w_t_nxt;
  logic [PERIOD_WIDTH-1:0] r_period, w_period_nxt;
  logic                    r_cnv, r_sck, r_rd, r_dv, r_busy, r_err;
  logic [31:0]             r_sample_cnt;
  logic                    w_cfg_ok, w_start, w_err_set, w_dv_nxt;

  assign w_cfg_ok = (period_cfg >= P_MIN);

  always_comb begin
    w_state_nxt  = r_state;
    w_t_nxt      = r_t + 1'b1;
    w_period_nxt = r_period;
    w_start      = 1'b0;
    w_err_set    = 1'b0;
    w_dv_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_t_nxt = '0;
        if (acq_en) begin
          if (w_cfg_ok) begin
            w_start      = 1'b1;
            w_period_nxt = period_cfg;
            w_state_nxt  = S_CNV;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      S_CNV:   if (r_t == T_CNV_LAST)   w_state_nxt = S_WAIT;
      S_WAIT:  if (r_t == T_WAIT_LAST)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_t == T_SHIFT_LAST) w_state_nxt = S_LATCH;
      S_LATCH: begin
        if (r_t == T_LATCH_LAST) begin
          w_state_nxt = S_HOLD;
          w_dv_nxt    = 1'b1;
        end
      end
      S_HOLD: begin
        // Frame boundary: chain straight into the next CNV so there is no gap cycle.
        if (r_t == r_period - 1'b1) begin
          w_t_nxt = '0;
          if (acq_en) begin
            w_state_nxt = S_CNV;
            if (w_cfg_ok) w_period_nxt = period_cfg;
            else          w_err_set    = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_t_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge adc_spi_clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_t          <= '0;
      r_period     <= '0;
      r_cnv        <= 1'b0;
      r_sck        <= 1'b0;
      r_rd         <= 1'b0;
      r_dv         <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_t      <= w_t_nxt;
      r_period <= w_period_nxt;
      r_cnv    <= (w_state_nxt == S_CNV);
      r_sck    <= (w_state_nxt == S_SHIFT);
      r_rd     <= (w_state_nxt == S_SHIFT);
      r_dv     <= w_dv_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      if (w_start)        r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
      if (w_start)         r_sample_cnt <= '0;
      else if (w_dv_nxt)   r_sample_cnt <= r_sample_cnt + 32'd1;
    end
  end

  assign adc_cnv        = r_cnv;
  assign adc_sck_en     = r_sck;
  assign reader_en_sync = r_rd;
  assign data_valid     = r_dv;
  assign sample_cnt     = r_sample_cnt;
  assign busy           = r_busy;
  assign cfg_err        = r_err;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer: per-frame waveform capture compared
// against hand-computed frame timing at default parameters.
module tb_adc_conv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acq_en = 1'b0;
  logic [15:0] period_cfg = '0;
  logic        adc_cnv, adc_sck_en, reader_en_sync, data_valid, busy, cfg_err;
  logic [31:0] sample_cnt;

  adc_conv_sequencer dut (
    .adc_spi_clk    (clk),
    .rst            (rst),
    .acq_en         (acq_en),
    .period_cfg     (period_cfg),
    .adc_cnv        (adc_cnv),
    .adc_sck_en     (adc_sck_en),
    .reader_en_sync (reader_en_sync),
    .data_valid     (data_valid),
    .sample_cnt     (sample_cnt),
    .busy           (busy),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int cnv_first, cnv_last, cnv_cnt;
  int sck_first, sck_last, sck_cnt;
  int rd_diff, dv_t, dv_cnt;
  logic [31:0] cnt_at_dv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Samples outputs for frame times t0..t1-1, starting at the sample point of t0.
  task automatic capture(input int t0, input int t1, input int drop_t,
                         input int chg_t, input logic [15:0] chg_val);
    cnv_first = -1; cnv_last = -1; cnv_cnt = 0;
    sck_first = -1; sck_last = -1; sck_cnt = 0;
    rd_diff = 0; dv_t = -1; dv_cnt = 0; cnt_at_dv = '1;
    for (int t = t0; t < t1; t++) begin
      if (adc_cnv) begin
        if (cnv_first < 0) cnv_first = t;
        cnv_last = t;
        cnv_cnt++;
      end
      if (adc_sck_en) begin
        if (sck_first < 0) sck_first = t;
        sck_last = t;
        sck_cnt++;
      end
      if (reader_en_sync !== adc_sck_en) rd_diff++;
      if (data_valid) begin
        dv_cnt++;
        dv_t = t;
        cnt_at_dv = sample_cnt;
      end
      if (t == drop_t) acq_en = 1'b0;
      if (t == chg_t)  period_cfg = chg_val;
      step();
    end
  endtask

  task automatic chk_frame(input string tag, input logic [31:0] exp_cnt);
    chk({tag, ".cnv_first"}, cnv_first, 0);
    chk({tag, ".cnv_last"},  cnv_last, 3);
    chk({tag, ".cnv_cnt"},   cnv_cnt, 4);
    chk({tag, ".sck_first"}, sck_first, 28);
    chk({tag, ".sck_last"},  sck_last, 45);
    chk({tag, ".sck_cnt"},   sck_cnt, 18);
    chk({tag, ".rd_diff"},   rd_diff, 0);
    chk({tag, ".dv_t"},      dv_t, 50);
    chk({tag, ".dv_cnt"},    dv_cnt, 1);
    chk({tag, ".cnt_at_dv"}, cnt_at_dv, exp_cnt);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".cnv"},  adc_cnv, 0);
    chk({tag, ".sck"},  adc_sck_en, 0);
    chk({tag, ".rd"},   reader_en_sync, 0);
    chk({tag, ".dv"},   data_valid, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask

  initial begin
    // Reset state
    step(3);
    chk_idle("rst");
    chk("rst.cnt", sample_cnt, 0);
    chk("rst.err", cfg_err, 0);

    // Start with period 80; three frames, acq_en dropped at t=10 of frame 3
    rst = 1'b0; acq_en = 1'b1; period_cfg = 16'd80;
    step();
    chk("start.busy", busy, 1);
    capture(0, 80, -1, -1, '0);
    chk_frame("f1", 1);
    capture(0, 80, -1, -1, '0);
    chk_frame("f2", 2);
    capture(0, 80, 10, -1, '0);
    chk_frame("f3", 3);
    chk_idle("stop.t80");
    capture(80, 100, -1, -1, '0);
    chk("stop.no_cnv", cnv_cnt, 0);
    chk("stop.cnt_hold", sample_cnt, 3);

    // Rejected start, then minimum period back-to-back
    period_cfg = 16'd50; acq_en = 1'b1;
    step();
    chk("rej.err", cfg_err, 1);
    chk_idle("rej");
    chk("rej.cnt_hold", sample_cnt, 3);
    capture(0, 5, -1, -1, '0);
    chk("rej.no_cnv", cnv_cnt, 0);
    period_cfg = 16'd51;
    step();
    chk("min.err_clr", cfg_err, 0);
    chk("min.cnv", adc_cnv, 1);
    chk("min.cnt_clr", sample_cnt, 0);
    capture(0, 51, -1, -1, '0);
    chk_frame("m1", 1);
    capture(0, 51, -1, -1, '0);
    chk_frame("m2", 2);

    // Mid-frame period changes take effect only at the boundary
    capture(0, 51, -1, 20, 16'd80);
    chk_frame("m3", 3);
    capture(0, 80, -1, 20, 16'd100);
    chk_frame("p80", 4);
    capture(0, 100, -1, -1, '0);
    chk_frame("p100", 5);
    chk("p100.next_cnv", adc_cnv, 1);
    chk("p100.err", cfg_err, 0);

    // Reset in the middle of SHIFT
    capture(0, 35, -1, -1, '0);
    chk("rstmid.sck", adc_sck_en, 1);
    rst = 1'b1;
    step();
    chk_idle("rstmid");
    chk("rstmid.cnt", sample_cnt, 0);
    rst = 1'b0;
    step();
    chk("restart.cnv", adc_cnv, 1);
    chk("restart.busy", busy, 1);
    capture(0, 100, -1, -1, '0);
    chk_frame("r1", 1);

    // Counter wrap
    capture(0, 20, -1, -1, '0);
    force dut.r_sample_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_sample_cnt;
    chk("wrap.preload", sample_cnt, 32'hFFFF_FFFF);
    capture(20, 100, -1, -1, '0);
    chk("wrap.dv_t", dv_t, 50);
    chk("wrap.cnt", cnt_at_dv, 0);

    acq_en = 1'b0;
    step(120);
    chk_idle("end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_conv_sequencer.md
Name: adc_conv_sequencer

Overview:
- Frame-level controller that paces AD4003 dual-channel ADC modules sharing one clock domain.
- Generates the CNV pulse, the 18-cycle SCK burst enable and the `reader_en_sync` window consumed by the per-channel shift registers.
- Issues a one-cycle `data_valid` strobe when the parallel `adc_data_arr` word is stable, plus a running sample counter.
- One instance drives all ADC modules in parallel; `data_valid` and `sample_cnt` feed the downstream packer/DMA.

Parameters:
- ADC_DATA_WIDTH, 18, bits per conversion; equals SCK burst length.
- CNV_HIGH_CYCLES, 4, `adc_cnv` high time in clock cycles (≥1).
- CONV_WAIT_CYCLES, 24, cycles from CNV fall to first SCK (≥1).
- READ_LAT, 4, cycles from last SCK to `data_valid`; covers the `adc_read_clk` delay and shift-register settle (≥1).
- PERIOD_WIDTH, 16, width of `period_cfg`.
- Derived, not overridable: MIN_PERIOD = CNV_HIGH_CYCLES + CONV_WAIT_CYCLES + ADC_DATA_WIDTH + READ_LAT + 1 (51 at defaults).

Ports:
- adc_spi_clk  in  1  80 MHz sequencing clock.
- rst  in  1  Synchronous, active-high reset.
- acq_en  in  1  Acquisition enable; level-sensitive.
- period_cfg  in  PERIOD_WIDTH  Frame period in clock cycles.
- adc_cnv  out  1  CNV to all ADCs (to OBUFDS at top).
- adc_sck_en  out  1  SCK gate enable; high for exactly ADC_DATA_WIDTH cycles per frame.
- reader_en_sync  out  1  Shift-enable for the capture shift registers; same timing as `adc_sck_en`.
- data_valid  out  1  One-cycle strobe; `adc_data_arr` is valid this cycle.
- sample_cnt  out  32  Completed frames since acquisition start.
- busy  out  1  High in every state except IDLE.
- cfg_err  out  1  Sticky; set on a rejected start.

Behaviour:
- Interface fixed: one clock `adc_spi_clk`; reset `rst` is synchronous and active-high.
- All outputs are registered.
- Reset value of every output is 0, including `sample_cnt` and `cfg_err`. `rst` asserted mid-frame forces IDLE and all outputs to 0 on the next edge, with no partial `data_valid`.
- FSM states: IDLE, CNV, WAIT, SHIFT, LATCH, HOLD. One cycle counter `t` is zeroed on CNV entry and counts every cycle of the frame.
- IDLE, `acq_en`=1:
  - If `period_cfg` ≥ MIN_PERIOD: latch `period_cfg` into `period_q`, clear `sample_cnt` and `cfg_err`, go to CNV.
  - Otherwise: set `cfg_err`=1, stay in IDLE.
- CNV: `adc_cnv`=1 for t = 0 .. CNV_HIGH_CYCLES-1, then WAIT.
- WAIT: all strobes low for CONV_WAIT_CYCLES cycles, then SHIFT.
- SHIFT: `adc_sck_en` = `reader_en_sync` = 1 for exactly ADC_DATA_WIDTH cycles (defaults: t = 28..45), then LATCH.
- LATCH: strobes low for READ_LAT cycles (t = 46..49), then HOLD.
- HOLD:
  - On the first HOLD cycle (t = 50 at defaults): `data_valid`=1 and `sample_cnt` increments in the same cycle (wraps 0xFFFF_FFFF→0).
  - Remain in HOLD until t = `period_q`-1.
  - At that cycle, if `acq_en`=1 then re-latch `period_cfg` and go to CNV, so the next `adc_cnv` rises at t = `period_q` with no gap cycle. If `period_cfg` < MIN_PERIOD at that point, set `cfg_err`, keep the old `period_q` and continue.
  - If `acq_en`=0 at that cycle, go to IDLE.
- `acq_en` falling mid-frame: the current frame completes, including `data_valid`; no further CNV.
- `period_cfg` changes mid-frame have no effect until the frame boundary.
- `period_q` = MIN_PERIOD exactly is legal: back-to-back frames, `data_valid` on the last cycle of each frame.
- `sample_cnt` holds its value in IDLE and is cleared only on a new start or on reset.

Test Plan:
- Reset, `acq_en`=1, `period_cfg`=80 -> `adc_cnv` high t=0..3; `adc_sck_en`/`reader_en_sync` high t=28..45 (18 cycles); `data_valid` at t=50; next `adc_cnv` rise at t=80; `sample_cnt`=1,2,3 on successive strobes.
- `period_cfg`=50 from IDLE -> `cfg_err`=1, `busy`=0, no `adc_cnv`. Then `period_cfg`=51 -> starts, `cfg_err` clears, frames exactly 51 cycles apart.
- `acq_en` dropped at t=10 of frame 3 -> frame 3 `data_valid` still at t=50, `sample_cnt`=3, IDLE at t=80, no further CNV.
- `period_cfg` changed 80→100 at t=20 -> current frame stays 80 cycles; the following frame is 100 cycles.
- `rst` pulsed at t=35 (mid-SHIFT) -> next edge: all outputs 0, `sample_cnt`=0, IDLE, no `data_valid`. Release with `acq_en`=1 -> clean restart at t=0.
- `sample_cnt` preloaded 0xFFFF_FFFF (force) -> next `data_valid` wraps it to 0.
